// File: rtl/relogio_mode_ctrl.sv
// rtl/relogio_mode_ctrl.sv - mode FSM, time-edit registers, stopwatch controls and blink for the clock
// Button levels become single-cycle events; every output comes from a register or decodes the state register.
module relogio_mode_ctrl #(
    parameter int BLINK_DIV = 50,
    parameter int HOURS     = 24,
    parameter int MINUTES   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_adj,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic [1:0] mode,
    output logic       clk_hold,
    output logic       clk_load,
    output logic [4:0] load_hour,
    output logic [5:0] load_minute,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       sw_lap,
    output logic       field_vis
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_CLOCK      = 2'd0,
        ST_SET_HOUR   = 2'd1,
        ST_SET_MINUTE = 2'd2,
        ST_STOPWATCH  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] btn_prev;
    logic [4:0] hour_n;
    logic [5:0] minute_n;
    logic       clk_load_n, sw_run_n, sw_clear_n, sw_lap_n, vis_n;
    logic [CW-1:0] blink_cnt, blink_cnt_n;
    logic       blink_rst;
    logic       in_set_n;
    logic       ev_mode, ev_adj, ev_ss, ev_lap;

    assign ev_mode = btn_mode & ~btn_prev[0];
    assign ev_adj  = btn_adj  & ~btn_prev[1];
    assign ev_ss   = btn_ss   & ~btn_prev[2];
    assign ev_lap  = btn_lap  & ~btn_prev[3];

    assign mode     = state;
    assign clk_hold = (state == ST_SET_HOUR) || (state == ST_SET_MINUTE);

    always_comb begin
        state_n    = state;
        hour_n     = load_hour;
        minute_n   = load_minute;
        clk_load_n = 1'b0;
        sw_run_n   = sw_run;
        sw_clear_n = 1'b0;
        sw_lap_n   = sw_lap;
        blink_rst  = 1'b0;
        case (state)
            ST_CLOCK: begin
                if (ev_mode) begin
                    state_n  = ST_SET_HOUR;
                    // Out-of-range counter values are clamped so the edit never exceeds the modulus
                    hour_n   = (int'(cur_hour) >= HOURS) ? 5'd0 : cur_hour;
                    minute_n = (int'(cur_minute) >= MINUTES) ? 6'd0 : cur_minute;
                end
            end
            ST_SET_HOUR: begin
                if (ev_mode) begin
                    state_n = ST_SET_MINUTE;
                end else if (ev_adj) begin
                    hour_n    = (int'(load_hour) + 1 >= HOURS) ? 5'd0 : load_hour + 5'd1;
                    blink_rst = 1'b1;
                end
            end
            ST_SET_MINUTE: begin
                if (ev_mode) begin
                    state_n    = ST_STOPWATCH;
                    clk_load_n = 1'b1;
                end else if (ev_adj) begin
                    minute_n  = (int'(load_minute) + 1 >= MINUTES) ? 6'd0 : load_minute + 6'd1;
                    blink_rst = 1'b1;
                end
            end
            default: begin
                if (ev_mode) begin
                    state_n  = ST_CLOCK;
                    sw_lap_n = 1'b0;
                end else if (ev_ss) begin
                    sw_run_n = ~sw_run;
                end else if (ev_lap) begin
                    if (sw_run) begin
                        sw_lap_n = ~sw_lap;
                    end else begin
                        sw_clear_n = 1'b1;
                        sw_lap_n   = 1'b0;
                    end
                end
            end
        endcase

        in_set_n    = (state_n == ST_SET_HOUR) || (state_n == ST_SET_MINUTE);
        blink_cnt_n = blink_cnt;
        vis_n       = field_vis;
        if (!in_set_n || blink_rst || (state_n != state)) begin
            blink_cnt_n = '0;
            vis_n       = 1'b1;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt_n = '0;
            vis_n       = ~field_vis;
        end else begin
            blink_cnt_n = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLOCK;
            btn_prev    <= 4'b0;
            load_hour   <= 5'd0;
            load_minute <= 6'd0;
            clk_load    <= 1'b0;
            sw_run      <= 1'b0;
            sw_clear    <= 1'b0;
            sw_lap      <= 1'b0;
            field_vis   <= 1'b1;
            blink_cnt   <= '0;
        end else begin
            state       <= state_n;
            btn_prev    <= {btn_lap, btn_ss, btn_adj, btn_mode};
            load_hour   <= hour_n;
            load_minute <= minute_n;
            clk_load    <= clk_load_n;
            sw_run      <= sw_run_n;
            sw_clear    <= sw_clear_n;
            sw_lap      <= sw_lap_n;
            field_vis   <= vis_n;
            blink_cnt   <= blink_cnt_n;
        end
    end

endmodule
